imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the decode stage. Takes the full
//  32-bit instruction word (not pre-sliced raw_imm) plus a side tag (e.g. PC), decodes
//  the format from the opcode, and sign-extends to XLEN. Output is registered behind a
//  2-entry skid buffer with valid/ready on both sides. Adds CSR zimm and an illegal flag.
// PARAMETERS
//  XLEN   32  result width; 32 or 64 only (any other value = elaboration error)
//  TAG_W  32  width of pass-through tag (PC / ROB id); carried unmodified
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      synchronous pipeline kill
//  in_valid   in   1      instruction/tag valid
//  in_ready   out  1      block can accept this cycle
//  instr      in   32     instruction word
//  in_tag     in   TAG_W  side tag
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts this cycle
//  imm        out  XLEN   extended immediate
//  zimm       out  5      CSR uimm instr[19:15], zero elsewhere
//  fmt        out  3      0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z(CSR imm), 7 illegal
//  out_tag    out  TAG_W  tag of the instruction on imm
// BEHAVIOUR
//  Decode (comb, on instr), i=instr, SX = sign-extend bit 31 to XLEN:
//  - LOAD 0000011, ITYPE 0010011, JALR 1100111, FENCE 0001111: I, SX(i[31:20])
//  - ENVIRONMENT 1110011: funct3[2]=1 -> Z, imm=0, zimm=i[19:15];
//    else -> I, SX(i[31:20])
//  - STORE 0100011: S, SX({i[31:25],i[11:7]})
//  - BRANCH 1100011: B, SX({i[31],i[7],i[30:25],i[11:8],1'b0})
//  - LUI 0110111, AUIPC 0010111: U, SX({i[31:12],12'b0}) (sign-extends when XLEN=64)
//  - JAL 1101111: J, SX({i[31],i[19:12],i[20],i[30:21],1'b0})
//  - RTYPE 0110011: fmt 0, imm=0
//  - i[1:0]!=2'b11 or any other opcode: fmt 7, imm=0, zimm=0
//  - zimm=0 for every fmt other than 6
//  Pipeline, 2 storage slots OUT (drives outputs) and SKID; in_ready = !skid_v (registered)
//  - accept = in_valid & in_ready; latency 1: accepted word is on outputs next cycle when
//    OUT was empty or draining
//  - OUT loads decoded input when (!out_v | out_ready): from SKID if skid_v, else from
//    input on accept; out_v <= skid_v | accept
//  - accept while out_v & !out_ready -> word goes to SKID, skid_v<=1, in_ready=0 next cycle
//  - out_v & out_ready & skid_v -> SKID moves to OUT, skid_v<=0; same-cycle accept
//    impossible (in_ready=0)
//  - OUT/SKID data hold stable while out_v & !out_ready (AXI-style; no drop, no dup)
//  - flush: out_v<=0, skid_v<=0 next edge; accept in that cycle is discarded;
//    flush overrides all
//  - order preserved: SKID always older than any new accept
//  Reset (async, any time incl. mid-transfer): out_v=0, skid_v=0 -> in_ready=1,
//  imm=0, zimm=0, fmt=0, out_tag=0; held words lost
//  Bubbles: out_valid=0 never consumes; data on outputs when out_valid=0 is don't-care
//  except after reset (zeros)
// TESTING
//  1 XLEN=32, out_ready=1, instr 0xFFF00093 (addi -1) tag 0x100 -> next cycle imm=0xFFFFFFFF,
//    fmt=1, out_tag=0x100
//  2 Formats: sw 0xFE112E23 -> imm=0xFFFFFFFC fmt 2; beq 0xFE000EE3 -> 0xFFFFFFFC fmt 3;
//    jal 0xFF9FF0EF -> 0xFFFFFFF8 fmt 5; lui 0x800000B7 -> 0x80000000 fmt 4;
//    csrrwi 0x3402D073 -> fmt 6 zimm=5 imm 0
//  3 XLEN=64: lui 0x800000B7 -> imm=0xFFFFFFFF80000000; instr 0x00000013 -> imm=0 fmt 1;
//    0x00000000 -> fmt 7 imm 0
//  4 Back-pressure: stream A,B,C back-to-back, out_ready=0 from cycle 2 -> A held, B in SKID,
//    in_ready=0, C held at input; release -> A,B,C one per cycle, no loss/dup
//  5 flush with OUT and SKID full and in_valid=1 -> next cycle out_valid=0, in_ready=1,
//    flushed word never appears
//  6 reset asserted between clock edges with out_valid=1 -> outputs zero/out_valid=0
//    immediately (no clock); after release first accepted word appears with 1-cycle latency

Source files
------------

// File: rtl/imm_gen_if.sv
// Decode-stage immediate generator bus: instruction/tag in, immediate/format/tag out, valid/ready both sides.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm;
  logic [4:0]       zimm;
  logic [2:0]       fmt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output flush, in_valid, instr, in_tag, out_ready,
    input  in_ready, out_valid, imm, zimm, fmt, out_tag
  );

  modport slave (
    input  flush, in_valid, instr, in_tag, out_ready,
    output in_ready, out_valid, imm, zimm, fmt, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Immediate generator: decodes format from the opcode, sign-extends to XLEN, registers the result
// behind a 2-slot (OUT + SKID) buffer. Latency 1; in_ready drops only while SKID is occupied.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  imm_gen_if.slave  bus
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]      i;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;
  logic [4:0]       dec_zimm;
  logic [2:0]       dec_fmt;

  assign i = bus.instr;

  // Every immediate format carries its sign in instr[31], so a 32-bit form extends uniformly.
  always_comb begin
    imm32    = 32'd0;
    dec_zimm = 5'd0;
    dec_fmt  = FMT_ILL;
    case (i[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        dec_fmt = FMT_I;
        imm32   = {{20{i[31]}}, i[31:20]};
      end
      7'b1110011: begin
        if (i[14]) begin
          dec_fmt  = FMT_Z;
          dec_zimm = i[19:15];
        end else begin
          dec_fmt = FMT_I;
          imm32   = {{20{i[31]}}, i[31:20]};
        end
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        imm32   = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        imm32   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        imm32   = {i[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        imm32   = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      7'b0110011: dec_fmt = FMT_R;
      default:    dec_fmt = FMT_ILL;
    endcase
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;
  end

  logic             out_v, skid_v;
  logic [XLEN-1:0]  out_imm, skid_imm;
  logic [4:0]       out_zimm, skid_zimm;
  logic [2:0]       out_fmt, skid_fmt;
  logic [TAG_W-1:0] out_tag, skid_tag;
  logic             accept;

  assign accept = bus.in_valid && !skid_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v     <= 1'b0;
      skid_v    <= 1'b0;
      out_imm   <= '0;
      out_zimm  <= '0;
      out_fmt   <= '0;
      out_tag   <= '0;
      skid_imm  <= '0;
      skid_zimm <= '0;
      skid_fmt  <= '0;
      skid_tag  <= '0;
    end else if (bus.flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else if (!out_v || bus.out_ready) begin
      // SKID holds the oldest word, and accept is blocked while it is full.
      if (skid_v) begin
        out_imm  <= skid_imm;
        out_zimm <= skid_zimm;
        out_fmt  <= skid_fmt;
        out_tag  <= skid_tag;
        out_v    <= 1'b1;
        skid_v   <= 1'b0;
      end else begin
        out_v <= accept;
        if (accept) begin
          out_imm  <= dec_imm;
          out_zimm <= dec_zimm;
          out_fmt  <= dec_fmt;
          out_tag  <= bus.in_tag;
        end
      end
    end else if (accept) begin
      skid_imm  <= dec_imm;
      skid_zimm <= dec_zimm;
      skid_fmt  <= dec_fmt;
      skid_tag  <= bus.in_tag;
      skid_v    <= 1'b1;
    end
  end

  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = out_v;
  assign bus.imm       = out_imm;
  assign bus.zimm      = out_zimm;
  assign bus.fmt       = out_fmt;
  assign bus.out_tag   = out_tag;

endmodule
